// File: rtl/mux_pkg.sv
// Shared types and constants for the button-driven mux select generator.
package mux_pkg;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    PRS       = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_t;

  localparam int DEB_CYCLES_DEF        = 8;
  localparam int PERIOD_ZERO_MEANS_256 = 256;

  // Last prescaler value of a period; a programmed period of 0 stands for 256.
  function automatic logic [7:0] presc_last(input logic [7:0] period);
    if (period == 8'd0) return 8'(PERIOD_ZERO_MEANS_256 - 1);
    return period - 8'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer for the four live inputs plus a debouncer on the
// select button that emits a one-cycle press pulse.
module btn_debounce
  import mux_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] raw,
  output logic [2:0] levels,
  output logic       press
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  logic [3:0] sync_p0;
  logic [3:0] sync_p1;
  deb_state_t state;
  logic [3:0] cnt;
  logic       btn;

  assign btn    = sync_p1[0];
  assign levels = sync_p1[3:1];

  // Entering a check state counts the current sample as the first stable one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      state   <= REL;
      cnt     <= '0;
      press   <= 1'b0;
    end else if (ena) begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      case (state)
        REL: begin
          if (btn) begin
            state <= PRESS_CHK;
            cnt   <= 4'd1;
          end
        end
        PRESS_CHK: begin
          if (!btn) begin
            state <= REL;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= PRS;
            cnt   <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PRS: begin
          if (!btn) begin
            state <= REL_CHK;
            cnt   <= 4'd1;
          end
        end
        REL_CHK: begin
          if (btn) begin
            state <= PRS;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= REL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mux_sel_driver.sv
// Mux select generator: sel toggles on debounced presses (manual) or on a
// programmable prescaler tick (auto); data bits pass through synchronized.
module mux_sel_driver
  import mux_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [2:0] levels;
  logic       press;
  logic       mode;
  logic [7:0] presc;
  logic [7:0] period;
  logic       tick;
  logic       sel;
  logic [3:0] tcnt;
  logic       unused_ui;

  assign unused_ui = &{1'b0, ui_in[7:4]};
  assign mode      = levels[0];

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .raw   (ui_in[3:0]),
    .levels(levels),
    .press (press)
  );

  // Manual mode holds the prescaler in clear, so the period is re-latched
  // every cycle there and auto mode always starts with the current uio_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      period <= '0;
      tick   <= 1'b0;
      sel    <= 1'b0;
      tcnt   <= '0;
    end else if (ena) begin
      if (press || tick) begin
        sel  <= ~sel;
        tcnt <= tcnt + 4'd1;
      end
      tick <= 1'b0;
      if (!mode || press) begin
        presc  <= '0;
        period <= uio_in;
      end else if (presc == presc_last(period)) begin
        presc  <= '0;
        period <= uio_in;
        tick   <= 1'b1;
      end else begin
        presc <= presc + 8'd1;
      end
    end
  end

  assign uo_out  = {tcnt, ~sel, sel, levels[2], levels[1]};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: doc/mux_sel_driver.md
MUX_SEL_DRIVER -- requirements
Module: mux_sel_driver

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 8: consecutive stable samples required to accept a button level change (range 2..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port ena, input, 1: 1 = block advances; 0 = all state held.
REQ-005 SHALL have port ui_in, input, 8:
- [0] select button
- [1] mode (0 manual, 1 auto)
- [2] data a
- [3] data b
- [7:4] unused
REQ-006 SHALL have port uio_in, input, 8: auto-toggle period in cycles; 0 means 256.
REQ-007 SHALL have port uo_out, output, 8:
- [0] a
- [1] b
- [2] sel
- [3] ~sel
- [7:4] toggle count
REQ-008 SHALL have ports uio_out and uio_oe, output, 8 each: both tied to 0.

Function
REQ-009 SHALL pass ui_in[3:0] through a 2-flop synchronizer; every function below uses synchronized values only.
REQ-010 SHALL drive uo_out[0] with synchronized a and uo_out[1] with synchronized b: 2-cycle latency from ui_in, unchanged by mode or sel.
REQ-011 SHALL debounce the button with FSM states REL, PRESS_CHK, PRS, REL_CHK:
- REL -> PRESS_CHK when sync button = 1.
- PRESS_CHK: counter increments each cycle while button = 1; on reaching DEB_CYCLES -> PRS and emit a one-cycle press pulse.
- PRESS_CHK -> REL with counter cleared if button = 0 before count completes.
- PRS -> REL_CHK when button = 0.
- REL_CHK -> REL after DEB_CYCLES consecutive 0 samples; -> PRS if button = 1 before that.
REQ-012 SHALL, in manual mode, toggle sel one cycle after each press pulse.
REQ-013 SHALL, in auto mode, run an 8-bit prescaler:
- Prescaler counts up each enabled cycle.
- On reaching period-1, prescaler clears and issues a tick.
- A tick toggles sel on the next cycle.
REQ-014 SHALL, in auto mode, clear the prescaler on a press pulse and toggle sel; a tick and a press pulse in the same cycle produce exactly one toggle.
REQ-015 SHALL hold the prescaler at 0 while in manual mode; a mode change takes effect on the cycle after the synchronized mode changes.
REQ-016 SHALL sample a uio_in period change at the next prescaler clear only.
REQ-017 SHALL drive uo_out[3] as ~sel, so exactly one of sel and ~sel is 1 in every cycle.
REQ-018 SHALL increment uo_out[7:4] on every sel toggle and wrap from 15 to 0.
REQ-019 SHALL, while ena = 0, freeze all state (synchronizers, FSM, counters, sel) and hold outputs.

Reset
REQ-020 SHALL, on rst asserted, asynchronously clear:
- synchronizers
- FSM to REL
- debounce counter
- prescaler
- latched period (=0, meaning 256)
- sel = 0
- toggle count = 0
Result: uo_out = 8'h08.
REQ-021 SHALL, on rst asserted mid-debounce or mid-period, discard the pending event; no toggle occurs on release of reset.
REQ-022 SHALL release rst asynchronously, with the first state update on the first clk edge after deassertion.

Structure
REQ-023 SHALL place the FSM state encoding, DEB_CYCLES default and PERIOD_ZERO_MEANS_256 constant in shared package mux_pkg.
REQ-024 SHALL implement the synchronizer-plus-debouncer as one sub-module, btn_debounce, emitting the press pulse; the prescaler, sel and count logic stay in the top.

Verification
REQ-025 SHALL cover: reset with ui_in=8'hFF -> uo_out=8'h08 while rst high; 2 cycles after release -> uo_out[1:0]=2'b11.
REQ-026 SHALL cover: manual mode, button high 20 cycles (DEB_CYCLES=8) -> exactly one toggle, sel=1, count=1; 3-cycle glitch -> no toggle.
REQ-027 SHALL cover: auto mode, uio_in=4 -> sel toggles every 4 cycles; after 16 toggles count wraps to 0.
REQ-028 SHALL cover: auto mode, uio_in=0 -> toggle interval 256 cycles.
REQ-029 SHALL cover: press pulse coincident with tick -> single toggle, count+1, prescaler restarts at 0.
REQ-030 SHALL cover: ena=0 for 50 cycles mid-period -> no state change; resume completes the remaining period exactly.
